// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, iteration default.
package mdu_pkg;

  localparam int unsigned ITER_DEFAULT = 32;

  // MDUCode encodings, shared with the instruction decoder.
  typedef enum logic [2:0] {
    OpNone  = 3'b000,
    OpMult  = 3'b001,
    OpMultu = 3'b010,
    OpDiv   = 3'b011,
    OpDivu  = 3'b100,
    OpMthi  = 3'b101,
    OpMtlo  = 3'b110
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFix
  } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface mdu_if;
  logic        start;
  logic [2:0]  MDUCode;
  logic [31:0] A;
  logic [31:0] B;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, MDUCode, A, B, flush,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, MDUCode, A, B, flush,
    output busy, done, HI, LO
  );
endinterface

// File: rtl/mdu_step.sv
// One iteration of the mult/div datapath.
// Multiply: acc = {partial product, remaining multiplier}; add opnd when acc[0] set, shift right.
// Divide:   acc = {partial remainder, dividend/quotient}; shift left, trial-subtract opnd,
//           keep the difference only when it does not go negative.
module mdu_step (
  input  logic        is_div,
  input  logic [63:0] acc,
  input  logic [31:0] opnd,
  output logic [63:0] acc_next
);
  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [33:0] trial;
  logic [31:0] rem_new;
  logic        q_bit;

  // Compute both iteration flavours and select by mode.
  always_comb begin
    sum     = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
    rem_sh  = {acc[63:32], acc[31]};
    trial   = {1'b0, rem_sh} - {2'b00, opnd};
    q_bit   = ~trial[33];
    // Remainder stays below the divisor (or equals a dividend prefix when dividing by zero),
    // so 32 bits always hold it.
    rem_new = q_bit ? trial[31:0] : rem_sh[31:0];
    if (is_div) begin
      acc_next = {rem_new, acc[30:0], q_bit};
    end else begin
      acc_next = {sum, acc[31:1]};
    end
  end
endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit holding HI/LO.
// Optional feature macro: MDU_SIGNED_EN enables signed mult/div (magnitude conversion + sign fix).
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned ITER = ITER_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);
  localparam int unsigned CntW = $clog2(ITER + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(ITER - 1);

  mdu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     acc_q, acc_d, step_acc;
  logic [31:0]     opnd_q, opnd_d;
  logic            is_div_q, is_div_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic            done_q, done_d;
  logic [31:0]     mag_a, mag_b, fix_hi, fix_lo;
  logic            accept;
  mdu_op_e         op;

  assign op     = mdu_op_e'(bus.MDUCode);
  assign accept = bus.start && !bus.flush;

`ifdef MDU_SIGNED_EN
  logic        signed_op, neg_a, neg_b;
  logic        res_neg_q, rem_neg_q;
  logic [63:0] prod_fix;

  assign signed_op = (op == OpMult) || (op == OpDiv);
  assign neg_a     = signed_op & bus.A[31];
  assign neg_b     = signed_op & bus.B[31];
  assign mag_a     = neg_a ? (~bus.A + 32'd1) : bus.A;
  assign mag_b     = neg_b ? (~bus.B + 32'd1) : bus.B;

  // Sign flags captured with the operands; only consumed in FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (state_q == StIdle && accept) begin
      res_neg_q <= neg_a ^ neg_b;
      rem_neg_q <= neg_a;
    end
  end

  assign prod_fix = res_neg_q ? (~acc_q + 64'd1) : acc_q;
  assign fix_hi   = is_div_q ? (rem_neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32])
                             : prod_fix[63:32];
  assign fix_lo   = is_div_q ? (res_neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0])
                             : prod_fix[31:0];
`else
  assign mag_a  = bus.A;
  assign mag_b  = bus.B;
  assign fix_hi = acc_q[63:32];
  assign fix_lo = acc_q[31:0];
`endif

  mdu_step u_step (
    .is_div   (state_q == StDiv),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (step_acc)
  );

  // Next-state logic: operation accept, iteration, result write-back, flush abort.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (op)
            OpMult, OpMultu: begin
              acc_d    = {32'd0, mag_b};
              opnd_d   = mag_a;
              is_div_d = 1'b0;
              cnt_d    = '0;
              state_d  = StMul;
            end
            OpDiv, OpDivu: begin
              acc_d    = {32'd0, mag_a};
              opnd_d   = mag_b;
              is_div_d = 1'b1;
              cnt_d    = '0;
              state_d  = StDiv;
            end
            OpMthi:  hi_d = bus.A;
            OpMtlo:  lo_d = bus.A;
            default: ;
          endcase
        end
      end
      StMul, StDiv: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) state_d = StFix;
      end
      StFix: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Squash discards the in-flight op, including a pending FIX write.
    if (bus.flush && state_q != StIdle) begin
      state_d = StIdle;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: expected HI/LO pushed on issue, popped and compared on done.
module tb_mdu;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  logic [63:0] exp_q[$];

  mdu_if bus ();

  mdu #(.ITER(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the architectural definition; returns {HI, LO}.
  function automatic logic [63:0] model(input logic [2:0] code, input logic [31:0] a,
                                        input logic [31:0] b);
    bit     sgn;
    longint sa, sb, p, q, r;
    logic [63:0] res;
`ifdef MDU_SIGNED_EN
    sgn = (code == 3'd1) || (code == 3'd3);
`else
    sgn = 1'b0;
`endif
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    case (code)
      3'd1, 3'd2: begin
        p = sa * sb;
        res = p;
      end
      3'd3, 3'd4: begin
        if (b == 32'd0) begin
          res = {a, (sgn && a[31]) ? 32'h1 : 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd5:    res = {a, lo_m};
      3'd6:    res = {hi_m, a};
      default: res = {hi_m, lo_m};
    endcase
    return res;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_unexpected: got done=1 expected no done");
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("sb_hi", bus.HI, e[63:32]);
        check("sb_lo", bus.LO, e[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int cycles = 0;
    while (bus.busy && cycles < 100) begin
      cycles++;
      step();
    end
    check("busy_cycles", 32'(cycles), 32'd33);
    check("done_pulse", {31'd0, bus.done}, 32'd1);
  endtask

  // Issue one op in the current cycle; for mult/div wait until it completes.
  task automatic run_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = model(code, a, b);
    bus.start = 1'b1;
    bus.MDUCode = code;
    bus.A = a;
    bus.B = b;
    if (code >= 3'd1 && code <= 3'd4) exp_q.push_back(r);
    hi_m = r[63:32];
    lo_m = r[31:0];
    step();
    bus.start = 1'b0;
    bus.MDUCode = 3'd0;
    if (code >= 3'd1 && code <= 3'd4) begin
      wait_done();
    end else begin
      check("nomd_busy", {31'd0, bus.busy}, 32'd0);
      check("nomd_hi", bus.HI, hi_m);
      check("nomd_lo", bus.LO, lo_m);
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.start = 1'b0;
    bus.MDUCode = 3'd0;
    bus.A = '0;
    bus.B = '0;
    bus.flush = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);

    // Directed cases, back to back.
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd1, 32'hFFFF_FFF9, 32'd3);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd4, 32'd5, 32'd0);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd0);

    // Moves in consecutive cycles.
    run_op(3'd6, 32'h1234, 32'd0);
    run_op(3'd5, 32'hABCD, 32'd0);
    check("mv_lo", bus.LO, 32'h1234);
    check("mv_hi", bus.HI, 32'hABCD);

    // Flush during iteration 10: no done, HI/LO unchanged.
    begin
      logic [63:0] dummy;
      dummy = model(3'd4, 32'd1000, 32'd7);
      bus.start = 1'b1;
      bus.MDUCode = 3'd4;
      bus.A = 32'd1000;
      bus.B = 32'd7;
      step();
      bus.start = 1'b0;
      repeat (9) step();
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      check("flush_busy", {31'd0, bus.busy}, 32'd0);
      repeat (40) step();
      check("flush_hi", bus.HI, hi_m);
      check("flush_lo", bus.LO, lo_m);
      if (dummy == 64'd0) $display("note: unexpected zero model result");
    end

    // Start during busy must be ignored.
    bus.start = 1'b1;
    bus.MDUCode = 3'd2;
    bus.A = 32'd123;
    bus.B = 32'd456;
    exp_q.push_back(model(3'd2, 32'd123, 32'd456));
    step();
    begin
      logic [63:0] r;
      r = model(3'd2, 32'd123, 32'd456);
      repeat (4) step();
      bus.start = 1'b1;
      bus.MDUCode = 3'd5;
      bus.A = 32'hDEAD_BEEF;
      step();
      bus.MDUCode = 3'd3;
      bus.A = 32'd99;
      bus.B = 32'd3;
      step();
      bus.start = 1'b0;
      bus.MDUCode = 3'd0;
      check("ign_hi", bus.HI, hi_m);
      check("ign_lo", bus.LO, lo_m);
      hi_m = r[63:32];
      lo_m = r[31:0];
      begin
        int cycles = 6;
        while (bus.busy && cycles < 100) begin
          cycles++;
          step();
        end
        check("ign_busy_cycles", 32'(cycles), 32'd33);
      end
      check("ign_res_hi", bus.HI, hi_m);
      check("ign_res_lo", bus.LO, lo_m);
    end
    step();

    // Randomized mix of all op codes.
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 6)), rnd_operand(), rnd_operand());
    end

    // Reset mid-divide.
    bus.start = 1'b1;
    bus.MDUCode = 3'd4;
    bus.A = 32'd77;
    bus.B = 32'd5;
    step();
    bus.start = 1'b0;
    repeat (15) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    hi_m = '0;
    lo_m = '0;
    check("mid_rst_hi", bus.HI, 32'd0);
    check("mid_rst_lo", bus.LO, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_done", {31'd0, bus.done}, 32'd0);
    repeat (40) step();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
